// File: rtl/scpu_mem_arb.sv
// Arbiter/sequencer for the scpu single-port data SRAM: shares it between the
// CPU load/store port and a debug/loader port that can halt CPU memory access.
module scpu_mem_arb #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_halt,
  output logic          halted,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Handshake: a requester holds req/we/addr/wdata stable until its gnt is seen
  // high in a cycle; the access is issued in that same cycle. Reads return two
  // cycles later as a one-cycle rvalid pulse with rdata held afterwards.

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       dbg_starved;
  logic       p1_valid;   // read issued last cycle; mem_rdata valid now
  logic       p1_dbg;     // owner of that read: 1=debug, 0=CPU
  logic       cpu_rd_pend;

  assign dbg_starved = (wait_cnt == MAX_W);
  assign cpu_rd_pend = p1_valid & ~p1_dbg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state logic; decisions use the registered state so a grant issued in
  // the cycle dbg_halt rises still completes.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (dbg_halt) state_nxt = DRAIN;
      DRAIN: begin
        if (!dbg_halt)         state_nxt = RUN;
        else if (!cpu_rd_pend) state_nxt = HALTED;
      end
      HALTED:  if (!dbg_halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Output logic: grants
  always_comb begin
    dbg_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          dbg_gnt = dbg_req & (~cpu_req | dbg_starved);
          cpu_gnt = cpu_req & ~dbg_gnt;
        end
        DRAIN, HALTED: dbg_gnt = dbg_req;
        default: begin
          dbg_gnt = 1'b0;
          cpu_gnt = 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = (state != RUN) | (cpu_req & ~cpu_gnt);
  assign mem_cs    = cpu_gnt | dbg_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Debug starvation counter; only meaningful while the CPU has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if ((state != RUN) || !dbg_req || dbg_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Read return pipeline: tag at issue, capture data one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid   <= 1'b0;
      p1_dbg     <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      p1_valid   <= mem_cs & ~mem_we;
      p1_dbg     <= dbg_gnt;
      cpu_rvalid <= p1_valid & ~p1_dbg;
      dbg_rvalid <= p1_valid & p1_dbg;
      if (p1_valid && !p1_dbg) cpu_rdata <= mem_rdata;
      if (p1_valid &&  p1_dbg) dbg_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_nxt == HALTED);
  end

endmodule

// File: tb/tb_scpu_mem_arb.sv
// Directed bench for scpu_mem_arb with a behavioural single-port SRAM model.
module tb_scpu_mem_arb;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_halt, halted;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] tb_mem [256];

  int checks   = 0;
  int failures = 0;

  scpu_mem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .halted(halted),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // Single-port SRAM: write in the access cycle, read data the cycle after.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    dbg_halt = 1'b0;
    mem_rdata = '0;
    cpu_drive(1'b1, 1'b0, 8'h00, 8'h00);
    dbg_drive(1'b1, 1'b0, 8'h00, 8'h00);

    // Reset state: grants forced low even with requests present
    mid();
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_halted", halted, 0);
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    dbg_drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    mid();
    check("idle_mem_cs", mem_cs, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_state", dut.state, ST_RUN);

    // CPU write then read-back of 0x10
    tick();
    cpu_drive(1'b1, 1'b1, 8'h10, 8'h5A);
    mid();
    check("wr_cpu_gnt", cpu_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 8'h10);
    check("wr_mem_wdata", mem_wdata, 8'h5A);
    check("wr_stall", cpu_stall, 0);
    tick();
    cpu_drive(1'b1, 1'b0, 8'h10, 8'h00);
    mid();
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_mem_we", mem_we, 0);
    tick();
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    mid();
    check("rd_rvalid_n1", cpu_rvalid, 0);
    tick();
    mid();
    check("rd_rvalid_n2", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 8'h5A);
    check("rd_dbg_rdata", dbg_rdata, 0);
    check("rd_dbg_rvalid", dbg_rvalid, 0);
    tick();
    mid();
    check("rd_rvalid_n3", cpu_rvalid, 0);
    check("rd_rdata_held", cpu_rdata, 8'h5A);

    // Debug starvation: CPU holds priority for MAX_WAIT cycles
    tick();
    cpu_drive(1'b1, 1'b0, 8'h30, 8'h00);
    dbg_drive(1'b1, 1'b1, 8'h40, 8'h77);
    for (int i = 1; i <= 5; i++) begin
      mid();
      check($sformatf("starve_dbg_gnt_%0d", i), dbg_gnt, (i == 5) ? 1 : 0);
      check($sformatf("starve_cpu_gnt_%0d", i), cpu_gnt, (i == 5) ? 0 : 1);
      check($sformatf("starve_stall_%0d", i), cpu_stall, (i == 5) ? 1 : 0);
      tick();
    end
    dbg_drive(1'b0, 1'b0, 8'h00, 8'h00);
    mid();
    check("starve_wait_cnt", dut.wait_cnt, 0);
    check("starve_cpu_regain", cpu_gnt, 1);
    check("starve_mem40", tb_mem[8'h40], 8'h77);
    tick();
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick(); tick(); tick();

    // Preload 0x01..0x03 through the debug port
    dbg_drive(1'b1, 1'b1, 8'h01, 8'hA1);
    mid(); check("pre_gnt1", dbg_gnt, 1);
    tick();
    dbg_drive(1'b1, 1'b1, 8'h02, 8'hA2);
    mid(); check("pre_gnt2", dbg_gnt, 1);
    tick();
    dbg_drive(1'b1, 1'b1, 8'h03, 8'hA3);
    mid(); check("pre_gnt3", dbg_gnt, 1);
    tick();

    // Interleaved back-to-back reads: CPU 0x01, debug 0x02, CPU 0x03
    dbg_drive(1'b0, 1'b0, 8'h00, 8'h00);
    cpu_drive(1'b1, 1'b0, 8'h01, 8'h00);
    mid(); check("il_gnt_c1", cpu_gnt, 1);
    tick();
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    dbg_drive(1'b1, 1'b0, 8'h02, 8'h00);
    mid(); check("il_gnt_d2", dbg_gnt, 1);
    tick();
    dbg_drive(1'b0, 1'b0, 8'h00, 8'h00);
    cpu_drive(1'b1, 1'b0, 8'h03, 8'h00);
    mid();
    check("il_gnt_c3", cpu_gnt, 1);
    check("il_c1_rvalid", cpu_rvalid, 1);
    check("il_c1_rdata", cpu_rdata, 8'hA1);
    check("il_c1_dbg_rvalid", dbg_rvalid, 0);
    tick();
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    mid();
    check("il_d2_rvalid", dbg_rvalid, 1);
    check("il_d2_rdata", dbg_rdata, 8'hA2);
    check("il_d2_cpu_rvalid", cpu_rvalid, 0);
    check("il_d2_cpu_held", cpu_rdata, 8'hA1);
    tick();
    mid();
    check("il_c3_rvalid", cpu_rvalid, 1);
    check("il_c3_rdata", cpu_rdata, 8'hA3);
    check("il_c3_dbg_held", dbg_rdata, 8'hA2);
    tick(); tick();

    // Halt while a CPU read is in flight
    cpu_drive(1'b1, 1'b0, 8'h10, 8'h00);
    mid(); check("h_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    dbg_halt = 1'b1;
    mid(); check("h_state_n1", dut.state, ST_RUN);
    tick();
    cpu_drive(1'b1, 1'b0, 8'h11, 8'h00);
    mid();
    check("h_state_n2", dut.state, ST_DRAIN);
    check("h_drain_rvalid", cpu_rvalid, 1);
    check("h_drain_rdata", cpu_rdata, 8'h5A);
    check("h_drain_cpu_gnt", cpu_gnt, 0);
    check("h_drain_stall", cpu_stall, 1);
    check("h_drain_halted", halted, 0);
    tick();
    dbg_drive(1'b1, 1'b1, 8'h20, 8'h3C);
    mid();
    check("h_state_n3", dut.state, ST_HALTED);
    check("h_halted", halted, 1);
    check("h_cpu_gnt_n3", cpu_gnt, 0);
    check("h_stall_n3", cpu_stall, 1);
    check("h_dbg_gnt", dbg_gnt, 1);
    check("h_mem_we", mem_we, 1);
    check("h_mem_addr", mem_addr, 8'h20);
    tick();
    dbg_drive(1'b0, 1'b0, 8'h00, 8'h00);
    dbg_halt = 1'b0;
    mid();
    check("h_still_halted", halted, 1);
    check("h_cpu_gnt_n4", cpu_gnt, 0);
    check("h_mem20", tb_mem[8'h20], 8'h3C);
    tick();
    mid();
    check("h_state_run", dut.state, ST_RUN);
    check("h_halted_clr", halted, 0);
    check("h_cpu_gnt_resume", cpu_gnt, 1);
    check("h_stall_resume", cpu_stall, 0);
    tick();
    cpu_drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick(); tick(); tick();

    // Reset the cycle after a debug read grant
    dbg_drive(1'b1, 1'b0, 8'h20, 8'h00);
    mid(); check("r_dbg_gnt", dbg_gnt, 1);
    tick();
    dbg_drive(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    mid(); check("r_rvalid_in_rst", dbg_rvalid, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("r_dbg_rvalid_%0d", i), dbg_rvalid, 0);
      check($sformatf("r_dbg_rdata_%0d", i), dbg_rdata, 0);
      check($sformatf("r_state_%0d", i), dut.state, ST_RUN);
      check($sformatf("r_halted_%0d", i), halted, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
